// File: rtl/seven_seg_scan_ctrl.sv
// Time-multiplexed 7-segment scan controller; value updates are applied only at frame boundaries.
// Define LEADING_ZERO_BLANK_EN to suppress leading zero digits (evaluated on the active value).
module seven_seg_scan_ctrl #(
    parameter int unsigned NUM_DIGITS   = 4,
    parameter int unsigned DIV_WIDTH    = 16,
    parameter int unsigned DIV_MAX      = 49999,
    parameter int unsigned BLANK_CYCLES = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic                    load,
    input  logic [NUM_DIGITS-1:0]   digit_en,
    output logic [6:0]              seg,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_tick,
    output logic                    upd_pending
);

    localparam int unsigned          IDX_W     = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [DIV_WIDTH-1:0] CNT_MAX   = DIV_WIDTH'(DIV_MAX);
    localparam logic [DIV_WIDTH-1:0] CNT_BLANK = DIV_WIDTH'(BLANK_CYCLES);
    localparam logic [DIV_WIDTH-1:0] CNT_ONE   = DIV_WIDTH'(1);
    localparam logic [IDX_W-1:0]     IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
    localparam logic [IDX_W-1:0]     IDX_ONE   = IDX_W'(1);

    typedef enum logic {
        ST_BLANK,
        ST_SHOW
    } state_t;

    localparam state_t ST_RESET = (BLANK_CYCLES > 0) ? ST_BLANK : ST_SHOW;

    logic [DIV_WIDTH-1:0]    cnt_q, cnt_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    state_t                  state_q, state_d;
    logic [4*NUM_DIGITS-1:0] active_q, active_d;
    logic [4*NUM_DIGITS-1:0] pending_q, pending_d;
    logic                    upd_pending_q, upd_pending_d;
    logic [6:0]              seg_q, seg_d;
    logic [NUM_DIGITS-1:0]   an_q, an_d;
    logic                    frame_tick_q, frame_tick_d;

    logic                    slot_end;
    logic                    wrap;
    logic [3:0]              cur_nib;
    logic                    cur_en;
    logic                    cur_lz_show;
    logic [NUM_DIGITS-1:0]   lz_show;

    function automatic logic [6:0] dec7(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0:    s = 7'b0111111;
            4'h1:    s = 7'b0000110;
            4'h2:    s = 7'b1011011;
            4'h3:    s = 7'b1001111;
            4'h4:    s = 7'b1100110;
            4'h5:    s = 7'b1101101;
            4'h6:    s = 7'b1111101;
            4'h7:    s = 7'b0000111;
            4'h8:    s = 7'b1111111;
            4'h9:    s = 7'b1101111;
            4'hA:    s = 7'b1110111;
            4'hB:    s = 7'b1111100;
            4'hC:    s = 7'b0111001;
            4'hD:    s = 7'b1011110;
            4'hE:    s = 7'b1111001;
            default: s = 7'b1110001;
        endcase
        return s;
    endfunction

`ifdef LEADING_ZERO_BLANK_EN
    // Digit k stays lit only if some nibble at or above k is non-zero; digit 0 always qualifies.
    always_comb begin
        lz_show = '1;
        for (int unsigned k = 1; k < NUM_DIGITS; k++) begin
            lz_show[k] = |(active_q >> (4 * k));
        end
    end
`else
    always_comb begin
        lz_show = '1;
    end
`endif

    // Slot prescaler and digit index; state tracks the region of the current cnt value.
    always_comb begin
        slot_end = (cnt_q == CNT_MAX);
        wrap     = slot_end && (idx_q == IDX_LAST);
        cnt_d    = slot_end ? '0 : cnt_q + CNT_ONE;
        idx_d    = idx_q;
        if (slot_end) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_ONE;
        end
        state_d = (cnt_d < CNT_BLANK) ? ST_BLANK : ST_SHOW;
    end

    always_comb begin
        cur_nib     = '0;
        cur_en      = 1'b0;
        cur_lz_show = 1'b0;
        for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
            if (idx_q == IDX_W'(k)) begin
                cur_nib     = active_q[4*k +: 4];
                cur_en      = digit_en[k];
                cur_lz_show = lz_show[k];
            end
        end
    end

    always_comb begin
        an_d         = '0;
        seg_d        = '0;
        frame_tick_d = wrap;
        case (state_q)
            ST_SHOW: begin
                if (cur_en && cur_lz_show) begin
                    an_d  = NUM_DIGITS'(1) << idx_q;
                    seg_d = dec7(cur_nib);
                end
            end
            default: begin
                an_d  = '0;
                seg_d = '0;
            end
        endcase
    end

    // A load coinciding with the wrap goes straight to active and never raises upd_pending.
    always_comb begin
        active_d      = active_q;
        pending_d     = pending_q;
        upd_pending_d = upd_pending_q;
        if (load) begin
            pending_d = value;
        end
        if (wrap) begin
            upd_pending_d = 1'b0;
            if (load) begin
                active_d = value;
            end else if (upd_pending_q) begin
                active_d = pending_q;
            end
        end else if (load) begin
            upd_pending_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q         <= '0;
            idx_q         <= '0;
            state_q       <= ST_RESET;
            active_q      <= '0;
            pending_q     <= '0;
            upd_pending_q <= 1'b0;
            seg_q         <= '0;
            an_q          <= '0;
            frame_tick_q  <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            idx_q         <= idx_d;
            state_q       <= state_d;
            active_q      <= active_d;
            pending_q     <= pending_d;
            upd_pending_q <= upd_pending_d;
            seg_q         <= seg_d;
            an_q          <= an_d;
            frame_tick_q  <= frame_tick_d;
        end
    end

    assign seg         = seg_q;
    assign an          = an_q;
    assign frame_tick  = frame_tick_q;
    assign upd_pending = upd_pending_q;

endmodule
